sound_sequencer: RTL and testbench

- Shares the single square-wave audio pin between four game sound requesters: death, level-up, score and jump.
- Latches one-cycle request pulses and grants by fixed priority; a higher-priority request preempts a lower one.
- Plays each sound as a short note sequence from a built-in table, setting each note's half-period and duration.
- Sits between the game FSM and the board audio output.

---
 rtl/sound_sequencer.sv | 169 ++++++++++++++++
 tb/tb_sound_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sound_sequencer.sv
// Shares one square-wave audio pin between four prioritised game sounds.
// Each request is latched, granted by fixed priority and played as a short note sequence from a ROM.
module sound_sequencer #(
  parameter int TICK_DIV = 25100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  input  logic       mute,
  output logic       audio_out,
  output logic       busy,
  output logic [1:0] active_id,
  output logic       done,
  output logic [1:0] done_id
);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_t;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  state_t      state, state_nx;
  logic [3:0]  pending, pending_nx;
  logic [3:0]  clear, drop;
  logic [1:0]  id_q, id_nx;
  logic [1:0]  note_q, note_nx;
  logic [16:0] hp_q, hp_nx;
  logic [16:0] hp_cnt, hp_cnt_nx;
  logic [15:0] pre_cnt, pre_cnt_nx;
  logic [9:0]  dur_cnt, dur_cnt_nx;
  logic        tone, tone_nx;
  logic [26:0] first_note, next_note;
  logic        tick_wrap, note_end;

  // Returns {half_period[16:0], duration_ticks[9:0]}; a zero half-period ends the sound.
  function automatic logic [26:0] note_rom(input logic [1:0] id, input logic [1:0] idx);
    case ({id, idx})
      4'b00_00: note_rom = {17'd20000, 10'd150};
      4'b00_01: note_rom = {17'd25000, 10'd150};
      4'b00_10: note_rom = {17'd30000, 10'd300};
      4'b01_00: note_rom = {17'd14261, 10'd100};
      4'b01_01: note_rom = {17'd11300, 10'd100};
      4'b01_10: note_rom = {17'd9500,  10'd200};
      4'b10_00: note_rom = {17'd9500,  10'd80};
      4'b10_01: note_rom = {17'd7100,  10'd120};
      4'b11_00: note_rom = {17'd14261, 10'd80};
      default:  note_rom = '0;
    endcase
  endfunction

  function automatic logic [1:0] lowest(input logic [3:0] p);
    casez (p)
      4'b???1: lowest = 2'd0;
      4'b??10: lowest = 2'd1;
      4'b?100: lowest = 2'd2;
      default: lowest = 2'd3;
    endcase
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] i);
    onehot = 4'b0001 << i;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      pending <= '0;
      id_q    <= '0;
      note_q  <= '0;
      hp_q    <= '0;
      hp_cnt  <= '0;
      pre_cnt <= '0;
      dur_cnt <= '0;
      tone    <= 1'b0;
    end else begin
      state   <= state_nx;
      pending <= pending_nx;
      id_q    <= id_nx;
      note_q  <= note_nx;
      hp_q    <= hp_nx;
      hp_cnt  <= hp_cnt_nx;
      pre_cnt <= pre_cnt_nx;
      dur_cnt <= dur_cnt_nx;
      tone    <= tone_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    id_nx      = id_q;
    note_nx    = note_q;
    hp_nx      = hp_q;
    hp_cnt_nx  = hp_cnt;
    pre_cnt_nx = pre_cnt;
    dur_cnt_nx = dur_cnt;
    tone_nx    = tone;
    clear      = '0;
    first_note = note_rom(id_q, 2'd0);
    next_note  = note_rom(id_q, note_q + 2'd1);
    tick_wrap  = (pre_cnt == TICK_LAST);
    note_end   = tick_wrap && (dur_cnt == 10'd1);

    case (state)
      IDLE: begin
        if (|pending) begin
          id_nx    = lowest(pending);
          clear    = onehot(id_nx);
          state_nx = LOAD;
        end
      end
      LOAD: begin
        {hp_nx, dur_cnt_nx} = first_note;
        note_nx    = 2'd0;
        hp_cnt_nx  = '0;
        pre_cnt_nx = '0;
        tone_nx    = 1'b1;
        state_nx   = PLAY;
      end
      PLAY: begin
        // Anything pending below the active index outranks the current sound.
        if (|(pending & (onehot(id_q) - 4'd1))) begin
          id_nx    = lowest(pending);
          clear    = onehot(id_nx);
          tone_nx  = 1'b0;
          state_nx = LOAD;
        end else if (note_end) begin
          if (note_q == 2'd2 || next_note[26:10] == '0) begin
            tone_nx  = 1'b0;
            state_nx = DONE;
          end else begin
            {hp_nx, dur_cnt_nx} = next_note;
            note_nx    = note_q + 2'd1;
            hp_cnt_nx  = '0;
            pre_cnt_nx = '0;
            tone_nx    = 1'b1;
          end
        end else begin
          if (hp_cnt == hp_q - 17'd1) begin
            hp_cnt_nx = '0;
            tone_nx   = ~tone;
          end else begin
            hp_cnt_nx = hp_cnt + 17'd1;
          end
          if (tick_wrap) begin
            pre_cnt_nx = '0;
            dur_cnt_nx = dur_cnt - 10'd1;
          end else begin
            pre_cnt_nx = pre_cnt + 16'd1;
          end
        end
      end
      DONE: begin
        tone_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // A repeat request for the sound already loading or playing is ignored.
    drop       = (state == LOAD || state == PLAY) ? onehot(id_q) : 4'b0000;
    pending_nx = (pending & ~clear) | (req & ~drop);
  end

  assign audio_out = tone & ~mute;
  assign busy      = (state == LOAD) || (state == PLAY);
  assign active_id = id_q;
  assign done      = (state == DONE);
  assign done_id   = done ? id_q : 2'd0;

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer: a timeline of request/check rows, then a reset-abort sequence.
module tb_sound_sequencer;

  localparam int TICK_DIV = 60;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req = '0;
  logic       mute = 1'b0;
  logic       audio_out;
  logic       busy;
  logic [1:0] active_id;
  logic       done;
  logic [1:0] done_id;

  sound_sequencer #(.TICK_DIV(TICK_DIV)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .mute      (mute),
    .audio_out (audio_out),
    .busy      (busy),
    .active_id (active_id),
    .done      (done),
    .done_id   (done_id)
  );

  always #5 clk = ~clk;

  // Row: at edge count 'at' compare outputs (if chk), then drive req for one edge and set mute.
  typedef struct {
    int         at;
    logic [3:0] req;
    logic       mute;
    logic       chk;
    logic       busy;
    logic       audio;
    logic [1:0] id;
    logic       done;
    logic [1:0] done_id;
  } row_t;

  row_t       rows[$];
  logic [1:0] exp_q[$];
  logic [1:0] act_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         mute_leak = 0;

  always @(negedge clk) begin
    if (reset_n && done) act_q.push_back(done_id);
    if (mute && audio_out) mute_leak++;
  end

  function automatic row_t mk(input int at, input logic [3:0] rq, input logic mu, input logic ck,
                              input logic b, input logic a, input logic [1:0] id,
                              input logic d, input logic [1:0] did);
    row_t r;
    r.at = at; r.req = rq; r.mute = mu; r.chk = ck;
    r.busy = b; r.audio = a; r.id = id; r.done = d; r.done_id = did;
    return r;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    req = '0;
  endtask

  task automatic check_outs(input string tag, input logic b, input logic a, input logic [1:0] id,
                            input logic d, input logic [1:0] did);
    check({tag, ".busy"}, int'(busy), int'(b));
    check({tag, ".audio"}, int'(audio_out), int'(a));
    check({tag, ".active_id"}, int'(active_id), int'(id));
    check({tag, ".done"}, int'(done), int'(d));
    if (d) check({tag, ".done_id"}, int'(done_id), int'(did));
  endtask

  initial begin
    // Jump at edge 1, preempted by death; repeat death request dropped, jump re-request latched.
    rows.push_back(mk(0,     4'b1000, 0, 0, 0, 0, 2'd0, 0, 2'd0));
    rows.push_back(mk(1,     4'b0000, 0, 1, 0, 0, 2'd0, 0, 2'd0));
    rows.push_back(mk(2,     4'b0000, 0, 1, 1, 0, 2'd3, 0, 2'd0));
    rows.push_back(mk(3,     4'b0000, 0, 1, 1, 1, 2'd3, 0, 2'd0));
    rows.push_back(mk(1003,  4'b0001, 0, 1, 1, 1, 2'd3, 0, 2'd0));
    rows.push_back(mk(1004,  4'b0000, 0, 1, 1, 1, 2'd3, 0, 2'd0));
    rows.push_back(mk(1005,  4'b0000, 0, 1, 1, 0, 2'd0, 0, 2'd0));
    rows.push_back(mk(1006,  4'b0000, 0, 1, 1, 1, 2'd0, 0, 2'd0));
    rows.push_back(mk(4803,  4'b0000, 0, 1, 1, 1, 2'd0, 0, 2'd0));
    rows.push_back(mk(5000,  4'b1001, 0, 1, 1, 1, 2'd0, 0, 2'd0));
    rows.push_back(mk(37005, 4'b0000, 0, 1, 1, 1, 2'd0, 0, 2'd0));
    rows.push_back(mk(37006, 4'b0000, 0, 1, 0, 0, 2'd0, 1, 2'd0));
    rows.push_back(mk(37007, 4'b0000, 0, 1, 0, 0, 2'd0, 0, 2'd0));
    rows.push_back(mk(37008, 4'b0000, 0, 1, 1, 0, 2'd3, 0, 2'd0));
    rows.push_back(mk(37009, 4'b0000, 0, 1, 1, 1, 2'd3, 0, 2'd0));
    rows.push_back(mk(41808, 4'b0000, 0, 1, 1, 1, 2'd3, 0, 2'd0));
    rows.push_back(mk(41809, 4'b0000, 0, 1, 0, 0, 2'd3, 1, 2'd3));
    rows.push_back(mk(41810, 4'b0000, 0, 1, 0, 0, 2'd3, 0, 2'd0));
    // Score and jump together: score first (9500 then 7100 half-period), then jump.
    rows.push_back(mk(42000, 4'b1100, 0, 1, 0, 0, 2'd3, 0, 2'd0));
    rows.push_back(mk(42001, 4'b0000, 0, 1, 0, 0, 2'd3, 0, 2'd0));
    rows.push_back(mk(42002, 4'b0000, 0, 1, 1, 0, 2'd2, 0, 2'd0));
    rows.push_back(mk(42003, 4'b0000, 0, 1, 1, 1, 2'd2, 0, 2'd0));
    rows.push_back(mk(46802, 4'b0000, 0, 1, 1, 1, 2'd2, 0, 2'd0));
    rows.push_back(mk(46803, 4'b0000, 0, 1, 1, 1, 2'd2, 0, 2'd0));
    rows.push_back(mk(53902, 4'b0000, 0, 1, 1, 1, 2'd2, 0, 2'd0));
    rows.push_back(mk(53903, 4'b0000, 0, 1, 1, 0, 2'd2, 0, 2'd0));
    rows.push_back(mk(54002, 4'b0000, 0, 1, 1, 0, 2'd2, 0, 2'd0));
    rows.push_back(mk(54003, 4'b0000, 0, 1, 0, 0, 2'd2, 1, 2'd2));
    rows.push_back(mk(54004, 4'b0000, 0, 1, 0, 0, 2'd2, 0, 2'd0));
    rows.push_back(mk(54005, 4'b0000, 0, 1, 1, 0, 2'd3, 0, 2'd0));
    rows.push_back(mk(54006, 4'b0000, 0, 1, 1, 1, 2'd3, 0, 2'd0));
    rows.push_back(mk(58805, 4'b0000, 0, 1, 1, 1, 2'd3, 0, 2'd0));
    rows.push_back(mk(58806, 4'b0000, 0, 1, 0, 0, 2'd3, 1, 2'd3));
    // Muted levelup: silent throughout, done after 400 ticks.
    rows.push_back(mk(59000, 4'b0010, 1, 1, 0, 0, 2'd3, 0, 2'd0));
    rows.push_back(mk(59002, 4'b0000, 1, 1, 1, 0, 2'd1, 0, 2'd0));
    rows.push_back(mk(59003, 4'b0000, 1, 1, 1, 0, 2'd1, 0, 2'd0));
    rows.push_back(mk(71003, 4'b0000, 1, 1, 1, 0, 2'd1, 0, 2'd0));
    rows.push_back(mk(83002, 4'b0000, 1, 1, 1, 0, 2'd1, 0, 2'd0));
    rows.push_back(mk(83003, 4'b0000, 1, 1, 0, 0, 2'd1, 1, 2'd1));
    rows.push_back(mk(83004, 4'b0000, 0, 1, 0, 0, 2'd1, 0, 2'd0));

    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    check("reset.done_id", int'(done_id), 0);
    reset_n = 1'b1;
    cyc = 0;

    for (int i = 0; i < rows.size(); i++) begin
      while (cyc < rows[i].at) step();
      if (rows[i].chk) begin
        check_outs($sformatf("row%0d", i), rows[i].busy, rows[i].audio, rows[i].id,
                   rows[i].done, rows[i].done_id);
        if (rows[i].done) exp_q.push_back(rows[i].done_id);
      end
      req  = rows[i].req;
      mute = rows[i].mute;
    end

    // Reset mid-death with score pending: everything clears at once and nothing resumes.
    req = 4'b0001;
    repeat (3) step();
    check_outs("death_start", 1'b1, 1'b1, 2'd0, 1'b0, 2'd0);
    repeat (100) step();
    req = 4'b0100;
    repeat (50) step();
    check_outs("pre_reset", 1'b1, 1'b1, 2'd0, 1'b0, 2'd0);
    #2 reset_n = 1'b0;
    #1;
    check_outs("async_reset", 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    check("async_reset.done_id", int'(done_id), 0);
    repeat (3) step();
    reset_n = 1'b1;
    repeat (200) step();
    check_outs("post_reset_idle", 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
    req = 4'b1000;
    repeat (2) step();
    check_outs("post_reset_req", 1'b1, 1'b0, 2'd3, 1'b0, 2'd0);
    step();
    check_outs("post_reset_play", 1'b1, 1'b1, 2'd3, 1'b0, 2'd0);

    check("done_count", act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      check($sformatf("done_seq%0d", i), int'(act_q[i]), int'(exp_q[i]));
    check("mute_leak", mute_leak, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
